// File: rtl/cam_pkg.sv
// Shared types for the CAM round-robin cache: request opcodes, FSM states, response payload.
package cam_pkg;

  localparam int unsigned CAM_WORDS  = 8;
  localparam int unsigned CAM_BITS   = 8;
  localparam int unsigned CAM_TAG_SZ = 8;
  localparam int unsigned CAM_STAT_W = 16;
  localparam int unsigned CAM_IDX_W  = $clog2(CAM_WORDS);

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_WRITE  = 2'd1,
    OP_INVAL  = 2'd2,
    OP_FLUSH  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Response payload; widths follow the package defaults.
  typedef struct packed {
    logic                  hit;
    logic [CAM_IDX_W-1:0]  index;
    logic [CAM_BITS-1:0]   data;
  } cam_rsp_t;

endpackage

// File: rtl/cam_rr_cache_if.sv
// Request/response/evict bundle for cam_rr_cache. CAM_STATS_EN adds hit_cnt/miss_cnt.
interface cam_rr_cache_if #(
  parameter int unsigned WORDS  = cam_pkg::CAM_WORDS,
  parameter int unsigned BITS   = cam_pkg::CAM_BITS,
  parameter int unsigned TAG_SZ = cam_pkg::CAM_TAG_SZ
`ifdef CAM_STATS_EN
  , parameter int unsigned STAT_W = cam_pkg::CAM_STAT_W
`endif
);
  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned CNT_W = $clog2(WORDS + 1);

  logic              req_valid;
  logic              req_ready;
  cam_pkg::op_e      req_op;
  logic [TAG_SZ-1:0] req_tag;
  logic [BITS-1:0]   req_data;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [BITS-1:0]   rsp_data;
  logic [IDX_W-1:0]  rsp_index;
  logic              evict_valid;
  logic [TAG_SZ-1:0] evict_tag;
  logic [BITS-1:0]   evict_data;
  logic              full;
  logic [CNT_W-1:0]  count;
`ifdef CAM_STATS_EN
  logic [STAT_W-1:0] hit_cnt;
  logic [STAT_W-1:0] miss_cnt;
`endif

  modport master (
    output req_valid, req_op, req_tag, req_data,
    input  req_ready, rsp_valid, rsp_hit, rsp_data, rsp_index,
    input  evict_valid, evict_tag, evict_data, full, count
`ifdef CAM_STATS_EN
    , input hit_cnt, miss_cnt
`endif
  );

  modport slave (
    input  req_valid, req_op, req_tag, req_data,
    output req_ready, rsp_valid, rsp_hit, rsp_data, rsp_index,
    output evict_valid, evict_tag, evict_data, full, count
`ifdef CAM_STATS_EN
    , output hit_cnt, miss_cnt
`endif
  );

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
module cam_prio_enc #(
  parameter  int unsigned WORDS = 8,
  localparam int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic [WORDS-1:0] vec,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx_c = '0;
    any_c = |vec;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (vec[i]) idx_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cam_rr_cache.sv
// Fully-associative CAM cache with auto-allocation, round-robin eviction,
// invalidate-by-tag and an entry-per-cycle flush. Optional macro: CAM_STATS_EN.
module cam_rr_cache #(
  parameter int unsigned WORDS  = cam_pkg::CAM_WORDS,
  parameter int unsigned BITS   = cam_pkg::CAM_BITS,
  parameter int unsigned TAG_SZ = cam_pkg::CAM_TAG_SZ
`ifdef CAM_STATS_EN
  , parameter int unsigned STAT_W = cam_pkg::CAM_STAT_W
`endif
) (
  input logic           clk,
  input logic           rst_,
  cam_rr_cache_if.slave bus
);
  import cam_pkg::*;

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned CNT_W = $clog2(WORDS + 1);

  logic [WORDS-1:0]  val_q;
  logic [TAG_SZ-1:0] tag_q  [WORDS];
  logic [BITS-1:0]   data_q [WORDS];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d, fidx_q, fidx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  cam_rsp_t          rsp_q, rsp_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              evict_valid_q, evict_valid_d;
  logic [TAG_SZ-1:0] evict_tag_q, evict_tag_d;
  logic [BITS-1:0]   evict_data_q, evict_data_d;
`ifdef CAM_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
`endif

  logic              wr_en, clr_en;
  logic [IDX_W-1:0]  wr_idx, clr_idx;
  logic [WORDS-1:0]  match_c;
  logic [IDX_W-1:0]  hit_idx_c, free_idx_c;
  logic              hit_c, free_c;
  logic              accept_c;

  // Tag compare against every valid entry.
  always_comb begin
    for (int i = 0; i < WORDS; i++) match_c[i] = val_q[i] && (tag_q[i] == bus.req_tag);
  end

  cam_prio_enc #(.WORDS(WORDS)) u_match_enc (.vec(match_c), .idx_c(hit_idx_c), .any_c(hit_c));
  cam_prio_enc #(.WORDS(WORDS)) u_free_enc  (.vec(~val_q),  .idx_c(free_idx_c), .any_c(free_c));

  assign accept_c = bus.req_valid && ready_q;

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q       <= ST_IDLE;
      rr_q          <= '0;
      fidx_q        <= '0;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      rsp_q         <= '0;
      rsp_valid_q   <= 1'b0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
      evict_data_q  <= '0;
`ifdef CAM_STATS_EN
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      fidx_q        <= fidx_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      rsp_q         <= rsp_d;
      rsp_valid_q   <= rsp_valid_d;
      evict_valid_q <= evict_valid_d;
      evict_tag_q   <= evict_tag_d;
      evict_data_q  <= evict_data_d;
`ifdef CAM_STATS_EN
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
`endif
    end
  end

  // Next-state, storage controls and response payload.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    fidx_d        = fidx_q;
    cnt_d         = cnt_q;
    rsp_d         = '0;
    rsp_valid_d   = 1'b0;
    evict_valid_d = 1'b0;
    evict_tag_d   = '0;
    evict_data_d  = '0;
    wr_en         = 1'b0;
    wr_idx        = '0;
    clr_en        = 1'b0;
    clr_idx       = '0;
`ifdef CAM_STATS_EN
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          case (bus.req_op)
            OP_LOOKUP: begin
              rsp_valid_d = 1'b1;
              if (hit_c) begin
                rsp_d.hit   = 1'b1;
                rsp_d.index = CAM_IDX_W'(hit_idx_c);
                rsp_d.data  = CAM_BITS'(data_q[hit_idx_c]);
              end
`ifdef CAM_STATS_EN
              if (hit_c && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + STAT_W'(1);
              if (!hit_c && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + STAT_W'(1);
`endif
            end
            OP_WRITE: begin
              rsp_valid_d = 1'b1;
              wr_en       = 1'b1;
              if (hit_c) begin
                wr_idx      = hit_idx_c;
                rsp_d.hit   = 1'b1;
                rsp_d.index = CAM_IDX_W'(hit_idx_c);
              end else if (free_c) begin
                wr_idx      = free_idx_c;
                cnt_d       = cnt_q + CNT_W'(1);
                rsp_d.index = CAM_IDX_W'(free_idx_c);
              end else begin
                // Full miss: displace the round-robin victim.
                wr_idx        = rr_q;
                rsp_d.index   = CAM_IDX_W'(rr_q);
                evict_valid_d = 1'b1;
                evict_tag_d   = tag_q[rr_q];
                evict_data_d  = data_q[rr_q];
                rr_d          = (rr_q == IDX_W'(WORDS - 1)) ? '0 : rr_q + IDX_W'(1);
              end
            end
            OP_INVAL: begin
              rsp_valid_d = 1'b1;
              if (hit_c) begin
                clr_en      = 1'b1;
                clr_idx     = hit_idx_c;
                cnt_d       = cnt_q - CNT_W'(1);
                rsp_d.hit   = 1'b1;
                rsp_d.index = CAM_IDX_W'(hit_idx_c);
              end
            end
            OP_FLUSH: begin
              state_d = ST_FLUSH;
              fidx_d  = '0;
            end
            default: ;
          endcase
        end
      end
      ST_FLUSH: begin
        clr_en  = 1'b1;
        clr_idx = fidx_q;
        if (val_q[fidx_q]) cnt_d = cnt_q - CNT_W'(1);
        if (fidx_q == IDX_W'(WORDS - 1)) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rr_d        = '0;
          fidx_d      = '0;
`ifdef CAM_STATS_EN
          hit_cnt_d   = '0;
          miss_cnt_d  = '0;
`endif
        end else begin
          fidx_d = fidx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Entry storage: allocate/overwrite on write, clear on invalidate or flush.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      val_q <= '0;
      for (int i = 0; i < WORDS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        val_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]  <= bus.req_tag;
        data_q[wr_idx] <= bus.req_data;
      end
      if (clr_en) begin
        val_q[clr_idx]  <= 1'b0;
        tag_q[clr_idx]  <= '0;
        data_q[clr_idx] <= '0;
      end
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_hit     = rsp_q.hit;
  assign bus.rsp_data    = BITS'(rsp_q.data);
  assign bus.rsp_index   = IDX_W'(rsp_q.index);
  assign bus.evict_valid = evict_valid_q;
  assign bus.evict_tag   = evict_tag_q;
  assign bus.evict_data  = evict_data_q;
  assign bus.full        = (cnt_q == CNT_W'(WORDS));
  assign bus.count       = cnt_q;
`ifdef CAM_STATS_EN
  assign bus.hit_cnt     = hit_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cam_rr_cache.sv
// Directed self-checking bench for cam_rr_cache (8 entries, 8-bit tag/data).
module tb_cam_rr_cache;
  import cam_pkg::*;

  logic clk = 1'b0;
  logic rst_;
  int   errors = 0;
  int   checks = 0;
  int   n;

  always #5 clk = ~clk;

  cam_rr_cache_if bus ();

  cam_rr_cache dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for one cycle; returns #1 after the accepting edge.
  task automatic send(input op_e op, input logic [7:0] tag, input logic [7:0] data);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_tag   = tag;
    bus.req_data  = data;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic hit, input logic [2:0] idx,
                         input logic [7:0] data, input logic ev);
    chk({tag, ".rsp_valid"},   32'(bus.rsp_valid),   32'd1);
    chk({tag, ".rsp_hit"},     32'(bus.rsp_hit),     32'(hit));
    chk({tag, ".rsp_index"},   32'(bus.rsp_index),   32'(idx));
    chk({tag, ".rsp_data"},    32'(bus.rsp_data),    32'(data));
    chk({tag, ".evict_valid"}, 32'(bus.evict_valid), 32'(ev));
  endtask

  initial begin
    rst_          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_LOOKUP;
    bus.req_tag   = '0;
    bus.req_data  = '0;

    // Reset state
    #2;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.count",     32'(bus.count),     32'd0);
    chk("rst.full",      32'(bus.full),      32'd0);
    chk("rst.evict",     32'(bus.evict_valid), 32'd0);
    @(posedge clk); #1;
    chk("rst.ready_held", 32'(bus.req_ready), 32'd0);
    @(negedge clk) rst_ = 1'b1;
    @(posedge clk); #1;
    chk("idle.req_ready", 32'(bus.req_ready), 32'd1);

    // 1: fill all entries
    for (int i = 0; i < 8; i++) begin
      send(OP_WRITE, 8'(32'h10 + i), 8'(32'hA0 + i));
      chk_rsp("fill", 1'b0, 3'(i), 8'h00, 1'b0);
      chk("fill.count", 32'(bus.count), 32'(i + 1));
    end
    chk("fill.full", 32'(bus.full), 32'd1);
    @(posedge clk); #1;
    chk("fill.pulse_end", 32'(bus.rsp_valid), 32'd0);

    // 2: round-robin eviction when full
    send(OP_WRITE, 8'h20, 8'hB0);
    chk_rsp("ev0", 1'b0, 3'd0, 8'h00, 1'b1);
    chk("ev0.tag",   32'(bus.evict_tag),  32'h10);
    chk("ev0.data",  32'(bus.evict_data), 32'hA0);
    chk("ev0.count", 32'(bus.count),      32'd8);
    send(OP_WRITE, 8'h21, 8'hB1);
    chk_rsp("ev1", 1'b0, 3'd1, 8'h00, 1'b1);
    chk("ev1.tag",  32'(bus.evict_tag),  32'h11);
    chk("ev1.data", 32'(bus.evict_data), 32'hA1);

    // 3: overwrite hit, then back-to-back lookup sees the new data
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_WRITE;
    bus.req_tag   = 8'h12;
    bus.req_data  = 8'hCC;
    @(posedge clk); #1;
    bus.req_op    = OP_LOOKUP;
    bus.req_data  = 8'h00;
    chk_rsp("wr_hit", 1'b1, 3'd2, 8'h00, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk_rsp("b2b_lookup", 1'b1, 3'd2, 8'hCC, 1'b0);
    send(OP_LOOKUP, 8'h99, 8'h00);
    chk_rsp("lookup_miss", 1'b0, 3'd0, 8'h00, 1'b0);

    // 4: invalidate then reallocate the freed slot; victim pointer unaffected
    send(OP_INVAL, 8'h13, 8'h00);
    chk_rsp("inval_hit", 1'b1, 3'd3, 8'h00, 1'b0);
    chk("inval.count", 32'(bus.count), 32'd7);
    chk("inval.full",  32'(bus.full),  32'd0);
    send(OP_INVAL, 8'h13, 8'h00);
    chk_rsp("inval_miss", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("inval_miss.count", 32'(bus.count), 32'd7);
    send(OP_WRITE, 8'h30, 8'hD3);
    chk_rsp("realloc", 1'b0, 3'd3, 8'h00, 1'b0);
    chk("realloc.count", 32'(bus.count), 32'd8);
    send(OP_WRITE, 8'h40, 8'hE0);
    chk_rsp("ev2", 1'b0, 3'd2, 8'h00, 1'b1);
    chk("ev2.tag",  32'(bus.evict_tag),  32'h12);
    chk("ev2.data", 32'(bus.evict_data), 32'hCC);
    send(OP_LOOKUP, 8'h30, 8'h00);
    chk_rsp("lookup_30", 1'b1, 3'd3, 8'hD3, 1'b0);

    // 5: flush with 8 valid entries
    send(OP_FLUSH, 8'h00, 8'h00);
    chk("flush.ready_low", 32'(bus.req_ready), 32'd0);
    chk("flush.no_rsp",    32'(bus.rsp_valid), 32'd0);
    n = 1;
    for (int k = 0; k < 20 && !bus.req_ready; k++) begin
      @(posedge clk); #1;
      if (!bus.req_ready) n++;
    end
    chk("flush.busy_cycles", 32'(n),             32'd8);
    chk("flush.rsp_valid",   32'(bus.rsp_valid), 32'd1);
    chk("flush.rsp_hit",     32'(bus.rsp_hit),   32'd0);
    chk("flush.count",       32'(bus.count),     32'd0);
    chk("flush.full",        32'(bus.full),      32'd0);
    @(posedge clk); #1;
    chk("flush.pulse_end", 32'(bus.rsp_valid), 32'd0);
    send(OP_LOOKUP, 8'h20, 8'h00);
    chk_rsp("post_flush", 1'b0, 3'd0, 8'h00, 1'b0);

    // 6: async reset during flush cycle 3
    for (int i = 0; i < 8; i++) send(OP_WRITE, 8'(32'h50 + i), 8'(32'h60 + i));
    chk("refill.count", 32'(bus.count), 32'd8);
    send(OP_FLUSH, 8'h00, 8'h00);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_flush.count", 32'(bus.count),     32'd5);
    chk("mid_flush.ready", 32'(bus.req_ready), 32'd0);
    #2 rst_ = 1'b0;
    #1;
    chk("arst.req_ready", 32'(bus.req_ready),   32'd0);
    chk("arst.rsp_valid", 32'(bus.rsp_valid),   32'd0);
    chk("arst.count",     32'(bus.count),       32'd0);
    chk("arst.full",      32'(bus.full),        32'd0);
    chk("arst.evict",     32'(bus.evict_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk) rst_ = 1'b1;
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) n++;
    end
    chk("arst.no_late_rsp", 32'(n),             32'd0);
    chk("arst.ready_back",  32'(bus.req_ready), 32'd1);
    send(OP_LOOKUP, 8'h55, 8'h00);
    chk_rsp("arst.lookup", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("arst.count_after", 32'(bus.count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
